// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: default sizing,
// scheduler state encoding and a small sizing helper.
package uart_pkg;

  localparam int unsigned DEF_NUM_REQ      = 32'd4;
  localparam int unsigned DEF_DATA_WIDTH   = 32'd8;
  localparam int unsigned DEF_GAP_CYCLES   = 32'd2;
  localparam int unsigned DEF_BUSY_TIMEOUT = 32'd8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } e_sched_state;

  // Larger of two sizing parameters, used to dimension the shared counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority pick: the first set request found searching
// upward from last_owner+1, wrapping modulo NUM_REQ.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned OWN_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   last_owner,
  output logic [OWN_W-1:0]   winner,
  output logic               valid
);

  logic [OWN_W-1:0] idx_s;

  // Scan from the farthest offset down to the nearest so the nearest hit wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx_s = OWN_W'((int'(last_owner) + i) % int'(NUM_REQ));
      if (req[idx_s]) begin
        winner = idx_s;
        valid  = 1'b1;
      end else begin
        winner = winner;
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Grants one requester, launches its byte with a one-cycle DATA_VALID, follows
// TX_BUSY through the frame and enforces an inter-frame gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic                          TX_BUSY,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          DATA_VALID,
  output logic                          PAR_EN,
  output logic [$clog2(NUM_REQ)-1:0]    OWNER,
  output logic                          ACTIVE,
  output logic                          TIMEOUT_ERR
);

  localparam int unsigned OWN_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_W    = $clog2(max_u(GAP_CYCLES, BUSY_TIMEOUT)) + 32'd1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 32'd0) ? GAP_CYCLES - 32'd1 : 32'd0;
  // The busy window closes on the edge where the counter reaches BUSY_TIMEOUT-1.
  localparam int unsigned BUSY_PRE = (BUSY_TIMEOUT > 32'd1) ? BUSY_TIMEOUT - 32'd2 : 32'd0;
  localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  e_sched_state            state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    launch_s;
  logic                    timeout_s;
  logic                    gap_done_s;
  logic                    busy_expire_s;
  logic [OWN_W-1:0]        arb_idx_s;
  logic                    arb_valid_s;

  logic [NUM_REQ-1:0]      gnt_r;
  logic [DATA_WIDTH-1:0]   p_data_r;
  logic                    data_valid_r;
  logic                    par_en_r;
  logic [OWN_W-1:0]        owner_r;
  logic                    active_r;
  logic                    timeout_err_r;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_arb (
    .req        (REQ),
    .last_owner (owner_r),
    .winner     (arb_idx_s),
    .valid      (arb_valid_s)
  );

  assign gap_done_s    = (GAP_CYCLES == 32'd0) || (cnt_r == CNT_W'(GAP_LAST));
  assign busy_expire_s = (BUSY_TIMEOUT < 32'd2) || (cnt_r == CNT_W'(BUSY_PRE));

  // Next-state, counter and launch/timeout decisions for the scheduler.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    launch_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_valid_s && !TX_BUSY) begin
          state_s  = LAUNCH;
          launch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        state_s = WAIT_BUSY;
        cnt_s   = '0;
      end
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_s = WAIT_DONE;
          cnt_s   = '0;
        end else if (busy_expire_s) begin
          state_s   = GAP;
          cnt_s     = '0;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          state_s = (GAP_CYCLES == 32'd0) ? IDLE : GAP;
          cnt_s   = '0;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_done_s) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output registers: capture the winner on selection, pulse strobes for one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt_r         <= '0;
      p_data_r      <= '0;
      data_valid_r  <= 1'b0;
      par_en_r      <= 1'b0;
      owner_r       <= OWN_W'(NUM_REQ - 32'd1);
      active_r      <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      active_r      <= (state_s != IDLE);
      timeout_err_r <= timeout_s;
      if (launch_s) begin
        gnt_r        <= GNT_ONE << arb_idx_s;
        data_valid_r <= 1'b1;
        p_data_r     <= REQ_DATA[arb_idx_s*DATA_WIDTH +: DATA_WIDTH];
        par_en_r     <= REQ_PAR_EN[arb_idx_s];
        owner_r      <= arb_idx_s;
      end else begin
        gnt_r        <= '0;
        data_valid_r <= 1'b0;
      end
    end
  end

  assign GNT         = gnt_r;
  assign P_DATA      = p_data_r;
  assign DATA_VALID  = data_valid_r;
  assign PAR_EN      = par_en_r;
  assign OWNER       = owner_r;
  assign ACTIVE      = active_r;
  assign TIMEOUT_ERR = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default build plus a zero-gap build.
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic        tx_busy;
  logic [3:0]  gnt;
  logic [7:0]  p_data;
  logic        data_valid;
  logic        par_en;
  logic [1:0]  owner;
  logic        active;
  logic        timeout_err;

  logic [3:0]  req_z;
  logic [31:0] req_data_z;
  logic [3:0]  req_par_en_z;
  logic        tx_busy_z;
  logic [3:0]  gnt_z;
  logic [7:0]  p_data_z;
  logic        data_valid_z;
  logic        par_en_z;
  logic [1:0]  owner_z;
  logic        active_z;
  logic        timeout_err_z;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_DATA(req_data), .REQ_PAR_EN(req_par_en),
    .TX_BUSY(tx_busy), .GNT(gnt), .P_DATA(p_data), .DATA_VALID(data_valid),
    .PAR_EN(par_en), .OWNER(owner), .ACTIVE(active), .TIMEOUT_ERR(timeout_err)
  );

  uart_tx_scheduler #(.GAP_CYCLES(0)) dut_z (
    .CLK(clk), .RST(rst), .REQ(req_z), .REQ_DATA(req_data_z), .REQ_PAR_EN(req_par_en_z),
    .TX_BUSY(tx_busy_z), .GNT(gnt_z), .P_DATA(p_data_z), .DATA_VALID(data_valid_z),
    .PAR_EN(par_en_z), .OWNER(owner_z), .ACTIVE(active_z), .TIMEOUT_ERR(timeout_err_z)
  );

  task automatic test_reset();
    rst = 1'b0; req = 4'b0; req_data = 32'h0; req_par_en = 4'b0; tx_busy = 1'b0;
    req_z = 4'b0; req_data_z = 32'h0; req_par_en_z = 4'b0; tx_busy_z = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
    checks++; if (par_en !== 1'b0) begin errors++; $display("FAIL reset_par_en: got %b expected 0", par_en); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h expected 00", p_data); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d expected 3", owner); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_request();
    bit idle_seen;
    req = 4'b0100; req_data = 32'h00A5_0000; req_par_en = 4'b0100;
    @(negedge clk);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL single_dv: got %b expected 1", data_valid); end
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL single_p_data: got %h expected a5", p_data); end
    checks++; if (par_en !== 1'b1) begin errors++; $display("FAIL single_par_en: got %b expected 1", par_en); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d expected 2", owner); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %b expected 1", active); end
    req = 4'b0; tx_busy = 1'b1;
    @(negedge clk);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_dv_pulse: got %b expected 0", data_valid); end
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt); end
    @(negedge clk); @(negedge clk);
    tx_busy = 1'b0;
    idle_seen = 1'b0;
    for (int c = 0; c < 20 && !idle_seen; c++) begin
      @(negedge clk);
      if (active === 1'b0) idle_seen = 1'b1;
    end
    checks++; if (!idle_seen) begin errors++; $display("FAIL single_idle: got active %b expected 0 within 20 cycles", active); end
  endtask

  task automatic test_round_robin();
    int k;
    int busy_left;
    int fall;
    int exp_idx;
    logic [3:0] par_v;
    bit idle_seen;
    k = 0; busy_left = 0; fall = 0; par_v = 4'b0101;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req = 4'hF; req_data = 32'h1312_1110; req_par_en = par_v;
    for (int c = 0; c < 200 && !(k == 5 && busy_left == 0); c++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        exp_idx = k % 4;
        checks++; if (gnt !== (4'b0001 << exp_idx)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001 << exp_idx); end
        checks++; if (p_data !== 8'h10 + 8'(exp_idx)) begin errors++; $display("FAIL rr_p_data[%0d]: got %h expected %h", k, p_data, 8'h10 + 8'(exp_idx)); end
        checks++; if (par_en !== par_v[exp_idx]) begin errors++; $display("FAIL rr_par_en[%0d]: got %b expected %b", k, par_en, par_v[exp_idx]); end
        if (k > 0) begin
          checks++; if (c - fall !== 4) begin errors++; $display("FAIL rr_gap[%0d]: got %0d cycles expected 4", k, c - fall); end
        end
        k++;
        if (k == 5) req = 4'b0;
        tx_busy = 1'b1;
        busy_left = 10;
      end else begin
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rr_gnt_idle: got %b expected 0000", gnt); end
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            tx_busy = 1'b0;
            fall = c;
          end
        end
      end
    end
    checks++; if (k !== 5) begin errors++; $display("FAIL rr_count: got %0d grants expected 5", k); end
    idle_seen = 1'b0;
    for (int c = 0; c < 20 && !idle_seen; c++) begin
      @(negedge clk);
      if (active === 1'b0) idle_seen = 1'b1;
    end
    checks++; if (!idle_seen) begin errors++; $display("FAIL rr_idle: got active %b expected 0 within 20 cycles", active); end
  endtask

  task automatic test_timeout();
    bit idle_seen;
    req = 4'b0001; req_data = 32'h0000_00C3; req_par_en = 4'b0;
    @(negedge clk);
    checks++; if (data_valid !== 1'b1 || gnt !== 4'b0001) begin errors++; $display("FAIL to_launch: got dv %b gnt %b expected 1 0001", data_valid, gnt); end
    req = 4'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      checks++; if (timeout_err !== (j == 8)) begin errors++; $display("FAIL to_pulse[%0d]: got %b expected %b", j, timeout_err, (j == 8)); end
      if (j == 9) begin
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL to_gap_active: got %b expected 1", active); end
      end
      if (j == 10) begin
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL to_idle_active: got %b expected 0", active); end
      end
    end
    req = 4'b0010; req_data = 32'h0000_3C00; req_par_en = 4'b0;
    @(negedge clk);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL to_next_dv: got %b expected 1", data_valid); end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_next_gnt: got %b expected 0010", gnt); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL to_next_p_data: got %h expected 3c", p_data); end
    req = 4'b0; tx_busy = 1'b1;
    @(negedge clk); @(negedge clk);
    tx_busy = 1'b0;
    idle_seen = 1'b0;
    for (int c = 0; c < 20 && !idle_seen; c++) begin
      @(negedge clk);
      if (active === 1'b0) idle_seen = 1'b1;
    end
    checks++; if (!idle_seen) begin errors++; $display("FAIL to_idle: got active %b expected 0 within 20 cycles", active); end
  endtask

  task automatic test_busy_in_idle();
    bit idle_seen;
    tx_busy = 1'b1;
    req = 4'b0100; req_data = 32'h0077_0000; req_par_en = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL busy_hold[%0d]: got gnt %b dv %b expected 0000 0", j, gnt, data_valid); end
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL busy_release_dv: got %b expected 1", data_valid); end
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL busy_release_gnt: got %b expected 0100", gnt); end
    checks++; if (p_data !== 8'h77) begin errors++; $display("FAIL busy_release_p_data: got %h expected 77", p_data); end
    req = 4'b0; tx_busy = 1'b1;
    @(negedge clk); @(negedge clk);
    tx_busy = 1'b0;
    idle_seen = 1'b0;
    for (int c = 0; c < 20 && !idle_seen; c++) begin
      @(negedge clk);
      if (active === 1'b0) idle_seen = 1'b1;
    end
    checks++; if (!idle_seen) begin errors++; $display("FAIL busy_idle: got active %b expected 0 within 20 cycles", active); end
  endtask

  task automatic test_reset_mid_frame();
    bit idle_seen;
    req = 4'b0001; req_data = 32'h0000_005A; req_par_en = 4'b0001;
    @(negedge clk);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL mid_dv: got %b expected 1", data_valid); end
    req = 4'b0; tx_busy = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (active !== 1'b1 || par_en !== 1'b1) begin errors++; $display("FAIL mid_wait_done: got active %b par_en %b expected 1 1", active, par_en); end
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_strobes: got gnt %b dv %b expected 0000 0", gnt, data_valid); end
    checks++; if (par_en !== 1'b0 || p_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got par_en %b p_data %h expected 0 00", par_en, p_data); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL mid_rst_owner: got %0d expected 3", owner); end
    checks++; if (active !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got active %b timeout %b expected 0 0", active, timeout_err); end
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1010; req_data = 32'hBB00_AA00; req_par_en = 4'b0010;
    @(negedge clk);
    checks++; if (data_valid !== 1'b1 || gnt !== 4'b0010) begin errors++; $display("FAIL mid_after_gnt: got dv %b gnt %b expected 1 0010", data_valid, gnt); end
    checks++; if (owner !== 2'd1) begin errors++; $display("FAIL mid_after_owner: got %0d expected 1", owner); end
    checks++; if (p_data !== 8'hAA || par_en !== 1'b1) begin errors++; $display("FAIL mid_after_data: got %h %b expected aa 1", p_data, par_en); end
    req = 4'b0; tx_busy = 1'b1;
    @(negedge clk); @(negedge clk);
    tx_busy = 1'b0;
    idle_seen = 1'b0;
    for (int c = 0; c < 20 && !idle_seen; c++) begin
      @(negedge clk);
      if (active === 1'b0) idle_seen = 1'b1;
    end
    checks++; if (!idle_seen) begin errors++; $display("FAIL mid_idle: got active %b expected 0 within 20 cycles", active); end
  endtask

  task automatic test_gap_zero();
    int k;
    int busy_left;
    int fall;
    k = 0; busy_left = 0; fall = 0;
    req_z = 4'b0001; req_data_z = 32'h0000_00E7; req_par_en_z = 4'b0;
    for (int c = 0; c < 100 && !(k == 2 && busy_left == 0); c++) begin
      @(negedge clk);
      if (data_valid_z === 1'b1) begin
        checks++; if (gnt_z !== 4'b0001 || p_data_z !== 8'hE7) begin errors++; $display("FAIL gap0_launch[%0d]: got gnt %b p_data %h expected 0001 e7", k, gnt_z, p_data_z); end
        if (k == 1) begin
          checks++; if (c - fall !== 2) begin errors++; $display("FAIL gap0_spacing: got %0d cycles expected 2", c - fall); end
        end
        k++;
        if (k == 2) req_z = 4'b0;
        tx_busy_z = 1'b1;
        busy_left = 3;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_busy_z = 1'b0;
          fall = c;
        end
      end
    end
    checks++; if (k !== 2) begin errors++; $display("FAIL gap0_count: got %0d launches expected 2", k); end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_timeout();
    test_busy_in_idle();
    test_reset_mid_frame();
    test_gap_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares a single UART transmitter among `NUM_REQ` byte producers. It sits between the producers and the UART TX top, which contains the FSM, serializer, parity calculator and output mux. It picks one pending requester and presents that requester's byte and parity enable to the transmitter with a one-cycle `DATA_VALID`. It then tracks the transmitter's `TX_BUSY` through the frame and enforces an inter-frame gap before the next grant.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 8: byte width.
- `GAP_CYCLES`, default 2: idle cycles after `TX_BUSY` falls and before the next grant. 0 is legal.
- `BUSY_TIMEOUT`, default 8: cycles allowed for `TX_BUSY` to rise after launch.

Ports:
- `CLK`, in, 1: single clock.
- `RST`, in, 1: reset, asynchronous, active-low.
- `REQ`, in, `NUM_REQ`: requester i has a byte pending. Held high until `GNT[i]`.
- `REQ_DATA`, in, `NUM_REQ*DATA_WIDTH`: byte of requester i, at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `REQ_PAR_EN`, in, `NUM_REQ`: parity enable for requester i's frame.
- `TX_BUSY`, in, 1: transmitter frame in progress.
- `GNT`, out, `NUM_REQ`: one-hot, one-cycle pulse. Byte i accepted.
- `P_DATA`, out, `DATA_WIDTH`: byte to transmitter.
- `DATA_VALID`, out, 1: one-cycle launch strobe to transmitter.
- `PAR_EN`, out, 1: parity enable to transmitter.
- `OWNER`, out, `$clog2(NUM_REQ)`: index of last granted requester.
- `ACTIVE`, out, 1: high in every state except IDLE.
- `TIMEOUT_ERR`, out, 1: one-cycle pulse when `TX_BUSY` fails to rise.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:** if any `REQ` is high and `TX_BUSY`=0, select the winner and go to LAUNCH.
  - Winner is the first set `REQ` bit searching upward from `OWNER+1`, wrapping modulo `NUM_REQ`.
  - Register `P_DATA`, `PAR_EN` and `OWNER` from the winner.
  - If `TX_BUSY`=1 in IDLE, stay in IDLE with no grant.
- **LAUNCH (exactly 1 cycle):** `DATA_VALID`=1 and `GNT[OWNER]`=1. Go to WAIT_BUSY with the timeout counter cleared.
- **WAIT_BUSY:**
  - `TX_BUSY`=1: go to WAIT_DONE.
  - Counter reaches `BUSY_TIMEOUT-1` without busy: pulse `TIMEOUT_ERR` and go to GAP.
- **WAIT_DONE:** on `TX_BUSY`=0, go to GAP. If `GAP_CYCLES`=0, go directly to IDLE.
- **GAP:** count `GAP_CYCLES` cycles, then go to IDLE.
- `P_DATA`, `PAR_EN` and `OWNER` hold from selection until the next selection.
- A `REQ` that drops before its grant is ignored. `REQ_DATA` is sampled only in the selection cycle.
- At most one `GNT` bit is ever high. `GNT` is never asserted outside LAUNCH.
- Counters are `$clog2(max(GAP_CYCLES, BUSY_TIMEOUT))+1` bits wide. No wrap is possible.

## Timing
- **Reset values (async, immediate, including mid-frame):**
  - State IDLE.
  - `GNT`=0, `DATA_VALID`=0, `PAR_EN`=0, `P_DATA`=0.
  - `OWNER`=`NUM_REQ-1`, so requester 0 wins first after reset.
  - `ACTIVE`=0, `TIMEOUT_ERR`=0, counters 0.
- **Launch latency:** `REQ` high at IDLE edge t gives `DATA_VALID`/`GNT` high in cycle t+1.
- **Requester handshake:** the requester must deassert `REQ` by cycle t+2, or present the next byte. Re-arbitration occurs no earlier than IDLE.
- **Frame-to-frame minimum:** `TX_BUSY` falls at cycle f, then the next `DATA_VALID` occurs at f+`GAP_CYCLES`+2.
- **Simultaneous requests:** all `REQ` high continuously gives grant order `OWNER+1`, `+2`, … cyclically. There is no starvation.
- `TX_BUSY` already high in the LAUNCH cycle is accepted at the first WAIT_BUSY edge.

## Structure
- Shared package `uart_pkg`:
  - state enum `e_sched_state` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP).
  - default width constants.
- One sub-module, `uart_rr_arbiter`: combinational rotate-priority pick.
  - Inputs: `REQ` vector and last owner.
  - Outputs: winner index and a valid flag.
- FSM, counters and output registers live in `uart_tx_scheduler`.

## Test plan
- **Reset then single request:** `REQ`=4'b0100, `REQ_DATA[2]`=8'hA5, `REQ_PAR_EN[2]`=1.
  - Expect `DATA_VALID` and `GNT`=4'b0100 in the cycle after request, with `P_DATA`=8'hA5, `PAR_EN`=1, `OWNER`=2.
- **All four requesting, model busy for 10 cycles per frame:** expect grant order 0,1,2,3,0.
  - Expect each `DATA_VALID` exactly `GAP_CYCLES`+2 cycles after the previous `TX_BUSY` fall.
- **`TX_BUSY` never rises:** expect `TIMEOUT_ERR` pulse 8 cycles after LAUNCH, then GAP, then IDLE.
  - Expect the next request granted normally.
- **`TX_BUSY` held high while in IDLE with `REQ`=1:** expect no `GNT` until busy drops.
- **`RST` asserted during WAIT_DONE:** all outputs immediately take reset values.
  - After release, with `REQ`=4'b1010, requester 1 wins.
- **`GAP_CYCLES`=0 build:** `TX_BUSY` fall to next `DATA_VALID` is 2 cycles.
